// File: rtl/lsu_ctrl.sv
// Load/store controller for a word-wide data memory port.
// Sub-word stores use read-modify-write; loads extend sign or zero.
module lsu_ctrl #(
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req,
    input  logic              req_we,
    input  logic [1:0]        req_size,
    input  logic              req_unsigned,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    output logic              busy,
    output logic              done,
    output logic              misalign,
    output logic [31:0]       rdata,
    output logic [ADDR_W-1:0] mem_a,
    output logic              mem_we,
    output logic [31:0]       mem_wd,
    input  logic [31:0]       mem_rd
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_RMW_RD,
        S_STORE,
        S_RESP
    } state_t;

    state_t            r_state;
    logic [1:0]        r_size;
    logic [1:0]        r_lane;
    logic              r_uns;
    logic [15:0]       r_wdata;
    logic              r_busy;
    logic              r_done;
    logic              r_mis;
    logic [31:0]       r_rdata;
    logic [ADDR_W-1:0] r_mem_a;
    logic              r_mem_we;
    logic [31:0]       r_mem_wd;

    logic              w_err;
    logic [7:0]        w_byte;
    logic [15:0]       w_half;
    logic [31:0]       w_ext;
    logic [31:0]       w_merge;

    always_comb begin
        w_err = (req_size == 2'b11)
              | ((req_size == 2'b01) & req_addr[0])
              | ((req_size == 2'b10) & (req_addr[1:0] != 2'b00));
    end

    always_comb begin
        w_byte = mem_rd[7:0];
        case (r_lane)
            2'd1:    w_byte = mem_rd[15:8];
            2'd2:    w_byte = mem_rd[23:16];
            2'd3:    w_byte = mem_rd[31:24];
            default: w_byte = mem_rd[7:0];
        endcase
        w_half = r_lane[1] ? mem_rd[31:16] : mem_rd[15:0];
        w_ext  = mem_rd;
        case (r_size)
            2'b00:   w_ext = {{24{~r_uns & w_byte[7]}}, w_byte};
            2'b01:   w_ext = {{16{~r_uns & w_half[15]}}, w_half};
            default: w_ext = mem_rd;
        endcase
    end

    // Read word with the addressed lane(s) replaced by the store data.
    always_comb begin
        w_merge = mem_rd;
        if (r_size == 2'b00) begin
            w_merge[{r_lane, 3'b000} +: 8] = r_wdata[7:0];
        end else if (r_lane[1]) begin
            w_merge[31:16] = r_wdata;
        end else begin
            w_merge[15:0] = r_wdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= S_IDLE;
            r_size   <= 2'b00;
            r_lane   <= 2'b00;
            r_uns    <= 1'b0;
            r_wdata  <= '0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_mis    <= 1'b0;
            r_rdata  <= '0;
            r_mem_a  <= '0;
            r_mem_we <= 1'b0;
            r_mem_wd <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (req) begin
                        r_size  <= req_size;
                        r_lane  <= req_addr[1:0];
                        r_uns   <= req_unsigned;
                        r_wdata <= req_wdata[15:0];
                        r_busy  <= 1'b1;
                        if (w_err) begin
                            r_done  <= 1'b1;
                            r_mis   <= 1'b1;
                            r_state <= S_RESP;
                        end else begin
                            r_mem_a <= {req_addr[ADDR_W-1:2], 2'b00};
                            if (!req_we) begin
                                r_state <= S_LOAD;
                            end else if (req_size == 2'b10) begin
                                r_mem_we <= 1'b1;
                                r_mem_wd <= req_wdata;
                                r_state  <= S_STORE;
                            end else begin
                                r_state <= S_RMW_RD;
                            end
                        end
                    end
                end
                S_LOAD: begin
                    r_rdata <= w_ext;
                    r_mem_a <= '0;
                    r_done  <= 1'b1;
                    r_state <= S_RESP;
                end
                S_RMW_RD: begin
                    r_mem_wd <= w_merge;
                    r_mem_we <= 1'b1;
                    r_state  <= S_STORE;
                end
                S_STORE: begin
                    r_mem_a  <= '0;
                    r_mem_we <= 1'b0;
                    r_mem_wd <= '0;
                    r_done   <= 1'b1;
                    r_state  <= S_RESP;
                end
                S_RESP: begin
                    r_done  <= 1'b0;
                    r_mis   <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign busy     = r_busy;
    assign done     = r_done;
    assign misalign = r_mis;
    assign rdata    = r_rdata;
    assign mem_a    = r_mem_a;
    assign mem_we   = r_mem_we;
    assign mem_wd   = r_mem_wd;

endmodule

// File: tb/tb_lsu_ctrl.sv
// Bench for lsu_ctrl: directed plan steps plus random traffic
// against a byte-array reference model of memory.
module tb_lsu_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req = 1'b0;
    logic        req_we = 1'b0;
    logic [1:0]  req_size = 2'b00;
    logic        req_unsigned = 1'b0;
    logic [31:0] req_addr = '0;
    logic [31:0] req_wdata = '0;
    logic        busy, done, misalign, mem_we;
    logic [31:0] rdata, mem_a, mem_wd, mem_rd;

    logic [31:0] wm [16];
    logic [7:0]  bm [64];
    logic [31:0] exp_rd = '0;
    int          total = 0;
    int          bad = 0;

    lsu_ctrl #(.ADDR_W(32)) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .req_we(req_we),
        .req_size(req_size), .req_unsigned(req_unsigned),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .busy(busy), .done(done), .misalign(misalign),
        .rdata(rdata), .mem_a(mem_a), .mem_we(mem_we),
        .mem_wd(mem_wd), .mem_rd(mem_rd)
    );

    always #5 clk = ~clk;

    assign mem_rd = wm[mem_a[5:2]];
    always @(posedge clk) if (mem_we) wm[mem_a[5:2]] <= mem_wd;

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] mword(input int idx);
        return {bm[4*idx+3], bm[4*idx+2], bm[4*idx+1], bm[4*idx]};
    endfunction

    function automatic logic [31:0] mload(input int a, input int nb,
                                          input bit uns);
        logic [31:0] v;
        v = '0;
        for (int i = 0; i < nb; i++) v |= 32'(bm[a+i]) << (8 * i);
        if (!uns && nb < 4 && v[8*nb-1]) v |= 32'hFFFF_FFFF << (8 * nb);
        return v;
    endfunction

    task automatic op(input bit b2b, input bit we, input logic [1:0] sz,
                      input bit uns, input logic [31:0] a,
                      input logic [31:0] wd);
        bit          err;
        int          nb, lat, n, wecnt, weat;
        logic [31:0] expw;
        nb  = 1 << sz;
        err = (sz == 3) || (sz == 1 && a[0]) || (sz == 2 && a[1:0] != 0);
        lat = err ? 1 : (!we ? 2 : (sz == 2 ? 2 : 3));
        if (!err && !we) exp_rd = mload(int'(a[5:0]), nb, uns);
        if (!err && we)
            for (int i = 0; i < nb; i++) bm[int'(a[5:0]) + i] = wd[8*i +: 8];
        expw = mword(int'(a[5:2]));
        if (!b2b) @(negedge clk);
        req = 1'b1; req_we = we; req_size = sz;
        req_unsigned = uns; req_addr = a; req_wdata = wd;
        if (b2b) begin
            @(negedge clk);
            chk("accept_busy", 64'(busy), 64'(0));
        end
        n = 0; wecnt = 0; weat = 0;
        while (1) begin
            @(negedge clk);
            n++;
            if (mem_we) begin
                wecnt++;
                weat = n;
                chk("mem_wd", 64'(mem_wd), 64'(expw));
            end
            if (done || n >= 8) break;
            chk("busy", 64'(busy), 64'(1));
            if (!err) chk("mem_a", 64'(mem_a), 64'({a[31:2], 2'b00}));
        end
        req = 1'b0;
        chk("done_seen", 64'(done), 64'(1));
        chk("latency", 64'(n), 64'(lat));
        chk("misalign", 64'(misalign), 64'(err));
        chk("rdata", 64'(rdata), 64'(exp_rd));
        chk("we_count", 64'(wecnt), 64'((we && !err) ? 1 : 0));
        if (we && !err) chk("we_cycle", 64'(weat), 64'(lat - 1));
        chk("resp_port", {mem_a, mem_wd}, 64'(0));
        chk("mem_word", 64'(wm[a[5:2]]), 64'(expw));
    endtask

    initial begin
        for (int i = 0; i < 16; i++) begin
            wm[i] = $urandom;
            for (int j = 0; j < 4; j++) bm[4*i+j] = wm[i][8*j +: 8];
        end
        #1;
        chk("reset_outs", {busy, done, misalign, mem_we, rdata, mem_a},
            '0);
        chk("reset_wd", 64'(mem_wd), 64'(0));
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        op(0, 1, 2'b10, 0, 32'h10, 32'hDEAD_BEEF);
        op(0, 0, 2'b10, 0, 32'h10, 0);
        chk("lw_plan", 64'(rdata), 64'(32'hDEAD_BEEF));
        op(0, 1, 2'b00, 0, 32'h12, 32'h0000_005A);
        chk("sb_word", 64'(wm[4]), 64'(32'hDE5A_BEEF));
        op(0, 0, 2'b10, 0, 32'h10, 0);
        chk("lw_after_sb", 64'(rdata), 64'(32'hDE5A_BEEF));
        op(0, 0, 2'b00, 0, 32'h13, 0);
        chk("lb", 64'(rdata), 64'(32'hFFFF_FFDE));
        op(0, 0, 2'b00, 1, 32'h13, 0);
        chk("lbu", 64'(rdata), 64'(32'h0000_00DE));
        op(0, 0, 2'b01, 0, 32'h10, 0);
        chk("lh", 64'(rdata), 64'(32'hFFFF_BEEF));
        op(0, 0, 2'b01, 1, 32'h10, 0);
        chk("lhu", 64'(rdata), 64'(32'h0000_BEEF));
        op(0, 1, 2'b01, 0, 32'h12, 32'h0000_1234);
        chk("sh_word", 64'(wm[4]), 64'(32'h1234_BEEF));
        op(0, 0, 2'b10, 0, 32'h12, 0);
        op(0, 0, 2'b01, 0, 32'h11, 0);
        op(0, 0, 2'b11, 0, 32'h10, 0);
        chk("err_rdata", 64'(rdata), 64'(32'h0000_BEEF));

        op(0, 0, 2'b10, 0, 32'h10, 0);
        op(1, 0, 2'b10, 0, 32'h14, 0);
        op(1, 0, 2'b10, 0, 32'h18, 0);

        @(negedge clk);
        req = 1'b1; req_we = 1'b1; req_size = 2'b00;
        req_unsigned = 1'b0; req_addr = 32'h11; req_wdata = 32'hA5;
        @(negedge clk);
        chk("rmw_busy", 64'(busy), 64'(1));
        rst_n = 1'b0;
        #1;
        chk("abort_outs", {busy, done, misalign, mem_we, rdata, mem_a},
            '0);
        chk("abort_wd", 64'(mem_wd), 64'(0));
        req = 1'b0;
        exp_rd = '0;
        @(negedge clk);
        chk("abort_nodone", 64'(done), 64'(0));
        rst_n = 1'b1;
        @(negedge clk);
        chk("abort_nodone2", 64'(done), 64'(0));
        chk("abort_word", 64'(wm[4]), 64'(32'h1234_BEEF));
        op(0, 0, 2'b10, 0, 32'h10, 0);
        chk("lw_after_rst", 64'(rdata), 64'(32'h1234_BEEF));

        for (int k = 0; k < 200; k++) begin
            op(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
               2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
               32'($urandom_range(0, 63)), $urandom);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/lsu_ctrl.md
# lsu_ctrl

Load/store controller that acts as the initiating side of the word-wide data memory port (`mem_a`, `mem_we`, `mem_wd`, `mem_rd`). It sits between the multicycle MIPS datapath and the data memory. It accepts one load or store request at a time, byte, halfword or word, and translates it into word accesses. Sub-word stores are performed as read-modify-write. Load data is extracted with sign or zero extension.

## Interface
- `ADDR_W`, default 32: width of request and memory addresses.
- `clk`  in  1  clock; all state updates on rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `req`  in  1  request valid; sampled only in IDLE.
- `req_we`  in  1  1 = store, 0 = load.
- `req_size`  in  2  00 byte, 01 halfword, 10 word, 11 reserved (treated as error).
- `req_unsigned`  in  1  load zero-extends when 1; ignored for word and for stores.
- `req_addr`  in  ADDR_W  byte address.
- `req_wdata`  in  32  store data; byte in [7:0], halfword in [15:0].
- `busy`  out  1  high in every state except IDLE.
- `done`  out  1  one-cycle completion pulse.
- `misalign`  out  1  high only together with `done`, for a rejected request.
- `rdata`  out  32  load result; valid from the `done` cycle and held until the next successful load.
- `mem_a`  out  ADDR_W  word address to memory, `{req_addr[ADDR_W-1:2], 2'b00}`.
- `mem_we`  out  1  memory write enable; memory writes on the rising edge.
- `mem_wd`  out  32  memory write data.
- `mem_rd`  in  32  memory read data; combinational from `mem_a` in the same cycle.

## Operation
- States: IDLE, LOAD, RMW_RD, STORE, RESP.
- **IDLE.** On `req=1`, capture `req_we`, `req_size`, `req_unsigned`, `req_addr` and `req_wdata`, then branch:
  - error → RESP with the error flag set. An error is any of: size 11; halfword with `addr[0]=1`; word with `addr[1:0]!=0`.
  - load → LOAD.
  - word store → STORE.
  - byte or halfword store → RMW_RD.
- **LOAD.** Drive `mem_a`. Register the extracted value from `mem_rd` into `rdata`, then → RESP.
- **RMW_RD.** Drive `mem_a`. Register `mem_rd` into the merge buffer, then → STORE.
- **STORE.** Drive `mem_a`, `mem_we=1` and `mem_wd`, then → RESP.
  - Word store: `mem_wd` = captured wdata.
  - Sub-word store: `mem_wd` = merge buffer with the addressed lane(s) replaced.
- **RESP.** `done=1`; `misalign` = error flag. → IDLE.
- Byte order is little-endian:
  - byte lane k = bits [8k+7:8k], where k = `addr[1:0]`.
  - halfword at `addr[1]=0` is [15:0]; at `addr[1]=1` it is [31:16].
- Load extension:
  - byte/halfword loads sign-extend from bit 7/15 unless `req_unsigned=1`, in which case they zero-fill.
  - word loads pass through unchanged.
- `rdata` is unchanged by stores and by errors.
- An erroring request makes no memory access: `mem_we` stays 0.
- Outside LOAD, RMW_RD and STORE: `mem_a=0`, `mem_we=0`, `mem_wd=0`.
- `req` in any non-IDLE state, including RESP, is ignored; there is no queue. The requester keeps `req` high until it sees `done`.

## Timing
- Request accepted at the rising edge ending cycle T (IDLE, `req=1`).
- Completion (`done` high) by request type:

| Request | States after T | `done` cycle |
|---|---|---|
| Load | LOAD in T+1 | T+2, `rdata` valid |
| Word store | STORE in T+1; memory updated at the edge ending T+1 | T+2 |
| Sub-word store | RMW_RD in T+1, STORE in T+2 | T+3 |
| Error | RESP in T+1 | T+1, with `misalign=1` |

- Maximum throughput under back-to-back requests (`req` held high): one load per 3 cycles, one sub-word store per 4 cycles.
- `mem_we` is high for exactly one cycle per store.
- Reset values: state IDLE; `busy`, `done`, `misalign`, `mem_we` = 0; `mem_a`, `mem_wd`, `rdata`, merge buffer = 0.
- Reset asserted mid-operation:
  - the block returns to IDLE immediately and `mem_we` drops asynchronously.
  - no `done` is produced for the aborted request.
  - memory changes only if a STORE-cycle rising edge completed before reset.

## Test plan
- **Word store then load.** sw `0xDEADBEEF` @`0x10`, then lw @`0x10` → `done` at T+2 for each; `rdata=0xDEADBEEF`; `mem_a=0x10`.
- **Byte store (read-modify-write).** With word `0xDEADBEEF` @`0x10`, sb `0x5A` @`0x12` → `mem_we` high only in T+2 with `mem_wd=0xDE5ABEEF`; `done` at T+3; a subsequent lw returns `0xDE5ABEEF`.
- **Extension.** With `0xDE5ABEEF` @`0x10`:
  - lb @`0x13` → `0xFFFFFFDE`
  - lbu @`0x13` → `0x000000DE`
  - lh @`0x10` → `0xFFFFBEEF`
  - lhu @`0x10` → `0x0000BEEF`
  - sh `0x1234` @`0x12` → word becomes `0x1234BEEF`
- **Misalignment.**
  - lw @`0x12` → `done` and `misalign` at T+1; `mem_we` never high; `rdata` unchanged.
  - lh @`0x11` and size 11 → same response.
- **Back-to-back.** `req` held high with lw @`0x10`, `0x14`, `0x18` (one per accept) → `done` every 3 cycles; `busy` low only in the accept cycles; a request presented during RESP is not accepted until the following IDLE cycle.
- **Reset mid-operation.** Assert `rst_n=0` during the RMW_RD cycle of an sb → all outputs 0 immediately, memory word unchanged, no `done`; after release, a new lw completes normally.
